// File: rtl/swg_window_collapser_pkg.sv
// Shared types and modulo-K address helper for the window collapser.
package swg_window_collapser_pkg;

  // A beat is NEW when it holds an element that has not been emitted yet.
  typedef enum logic {
    BEAT_NEW = 1'b0,
    BEAT_OLD = 1'b1
  } beat_class_e;

  // (a + b) mod k, assuming a < k and b <= k.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned k);
    int unsigned s;
    s = a + b;
    return (s >= k) ? (s - k) : s;
  endfunction

endpackage

// File: rtl/swg_collapse_history.sv
// Holds the last DEPTH emitted elements so overlapping beats can be checked.
// Ports: clk; we/addr/wdata synchronous write; rdata asynchronous read of addr.
module swg_collapse_history #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage only; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/swg_window_collapser.sv
// Collapses a stream of K-element windows (stride S) back into the unique
// feature-map element stream, optionally checking overlapping beats.
// Ports: ap_clk/ap_rst_n; in0_V_V_* window beat input (AXI-S);
//        out_V_V_* reconstructed element output (AXI-S);
//        mismatch_clr/mismatch sticky overlap-check flag; frame_done pulse.
module swg_window_collapser
  import swg_window_collapser_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned SIMD        = 1,
  parameter int unsigned KERNEL      = 3,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned NUM_WINDOWS = 64,
  parameter int unsigned CHECK_EN    = 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
  input  logic                      in0_V_V_TVALID,
  output logic                      in0_V_V_TREADY,
  output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA,
  output logic                      out_V_V_TVALID,
  input  logic                      out_V_V_TREADY,
  input  logic                      mismatch_clr,
  output logic                      mismatch,
  output logic                      frame_done
);

  localparam int unsigned DW = BIT_WIDTH * SIMD;
  localparam int unsigned PW = $clog2(KERNEL + 1);
  localparam int unsigned WW = $clog2(NUM_WINDOWS + 1);

  logic [PW-1:0] pos;
  logic [PW-1:0] base;
  logic [WW-1:0] win;

  beat_class_e   cls_c;
  logic [PW-1:0] addr_c;
  logic          in_hs_c;
  logic          pos_last_c;
  logic          win_last_c;
  logic          diff_c;
  logic [DW-1:0] hist_rd_c;

  // Classification, history address, ready and handshake.
  always_comb begin
    cls_c          = BEAT_OLD;
    addr_c         = PW'(wrap_add(32'(base), 32'(pos), KERNEL));
    in0_V_V_TREADY = 1'b0;
    // pos >= K-S written as pos+S >= K to stay non-constant when S==K.
    if (win == '0 || ({1'b0, pos} + (PW+1)'(STRIDE)) >= (PW+1)'(KERNEL))
      cls_c = BEAT_NEW;
    if (ap_rst_n)
      in0_V_V_TREADY = (cls_c == BEAT_OLD) || !out_V_V_TVALID || out_V_V_TREADY;
    in_hs_c    = in0_V_V_TVALID && in0_V_V_TREADY;
    pos_last_c = (pos == PW'(KERNEL - 1));
    win_last_c = (win == WW'(NUM_WINDOWS - 1));
    diff_c     = (CHECK_EN != 0) && in_hs_c && (cls_c == BEAT_OLD) &&
                 (hist_rd_c != in0_V_V_TDATA);
  end

  if (CHECK_EN != 0) begin : g_hist
    swg_collapse_history #(
      .DEPTH (KERNEL),
      .WIDTH (DW),
      .AW    (PW)
    ) u_hist (
      .clk   (ap_clk),
      .we    (in_hs_c && (cls_c == BEAT_NEW)),
      .addr  (addr_c),
      .wdata (in0_V_V_TDATA),
      .rdata (hist_rd_c)
    );
  end else begin : g_nohist
    assign hist_rd_c = in0_V_V_TDATA;
  end

  // Window position counters; base tracks (win*S) mod K.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pos        <= '0;
      win        <= '0;
      base       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_hs_c && pos_last_c && win_last_c;
      if (in_hs_c) begin
        if (pos_last_c) begin
          pos <= '0;
          if (win_last_c) begin
            win  <= '0;
            base <= '0;
          end else begin
            win  <= win + 1'b1;
            base <= PW'(wrap_add(32'(base), STRIDE, KERNEL));
          end
        end else begin
          pos <= pos + 1'b1;
        end
      end
    end
  end

  // Output register slice for NEW beats.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_V_V_TDATA  <= '0;
      out_V_V_TVALID <= 1'b0;
    end else if (in_hs_c && (cls_c == BEAT_NEW)) begin
      out_V_V_TDATA  <= in0_V_V_TDATA;
      out_V_V_TVALID <= 1'b1;
    end else if (out_V_V_TREADY) begin
      out_V_V_TVALID <= 1'b0;
    end
  end

  // Sticky mismatch flag; a new mismatch overrides a clear.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)         mismatch <= 1'b0;
    else if (diff_c)       mismatch <= 1'b1;
    else if (mismatch_clr) mismatch <= 1'b0;
  end

endmodule

// File: tb/tb_swg_window_collapser.sv
// Directed bench for swg_window_collapser: K=3/S=1/NW=64 and K=3/S=3/NW=4.
module tb_swg_window_collapser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // DUT a: overlapping windows
  logic [7:0] a_in_data, a_out_data;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr, a_mis, a_fd;

  swg_window_collapser #(
    .BIT_WIDTH(8), .SIMD(1), .KERNEL(3), .STRIDE(1), .NUM_WINDOWS(64), .CHECK_EN(1)
  ) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(a_in_data), .in0_V_V_TVALID(a_in_valid), .in0_V_V_TREADY(a_in_ready),
    .out_V_V_TDATA(a_out_data), .out_V_V_TVALID(a_out_valid), .out_V_V_TREADY(a_out_ready),
    .mismatch_clr(a_clr), .mismatch(a_mis), .frame_done(a_fd)
  );

  // DUT b: non-overlapping windows (S==K)
  logic [7:0] b_in_data, b_out_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr, b_mis, b_fd;

  swg_window_collapser #(
    .BIT_WIDTH(8), .SIMD(1), .KERNEL(3), .STRIDE(3), .NUM_WINDOWS(4), .CHECK_EN(1)
  ) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TDATA(b_in_data), .in0_V_V_TVALID(b_in_valid), .in0_V_V_TREADY(b_in_ready),
    .out_V_V_TDATA(b_out_data), .out_V_V_TVALID(b_out_valid), .out_V_V_TREADY(b_out_ready),
    .mismatch_clr(b_clr), .mismatch(b_mis), .frame_done(b_fd)
  );

  // Monitors sample on the falling edge.
  logic [7:0] a_got[$];
  int a_fd_cnt = 0;
  int a_old_stall = 0;
  logic a_stall_prev = 1'b0;
  logic [7:0] a_stall_data = '0;

  always @(negedge clk) begin
    if (rst_n && a_stall_prev) begin
      check_eq("stall_hold_valid", int'(a_out_valid), 1);
      check_eq("stall_hold_data", int'(a_out_data), int'(a_stall_data));
    end
    a_stall_prev = rst_n && a_out_valid && !a_out_ready;
    a_stall_data = a_out_data;
    if (rst_n && a_out_valid && a_out_ready) a_got.push_back(a_out_data);
    if (rst_n && a_in_valid && a_in_ready && a_out_valid && !a_out_ready) a_old_stall++;
    if (a_fd) a_fd_cnt++;
  end

  logic [7:0] b_got[$];
  int b_in_cyc[$];
  int b_out_cyc[$];
  int b_fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && b_in_valid && b_in_ready) b_in_cyc.push_back(cyc);
    if (rst_n && b_out_valid && b_out_ready) begin
      b_got.push_back(b_out_data);
      b_out_cyc.push_back(cyc);
    end
    if (b_fd) b_fd_cnt++;
  end

  // Random sink backpressure when enabled.
  bit bp_en = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) a_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present one beat and return just after the edge that accepts it.
  task automatic send_a(input logic [7:0] d);
    int n;
    n = 0;
    a_in_data  = d;
    a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check_eq("send_a_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    n = 0;
    b_in_data  = d;
    b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check_eq("send_b_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Ramp frame for K=3,S=1,NW=64; beat index bad_idx is replaced by 99.
  task automatic ramp_frame_a(input int bad_idx, input int nbeats);
    int idx;
    for (int w = 0; w < 64; w++) begin
      for (int p = 0; p < 3; p++) begin
        idx = 3 * w + p;
        if (idx < nbeats) begin
          if (idx == bad_idx) begin
            check_eq("mismatch_before_bad", int'(a_mis), 0);
            send_a(8'd99);
            check_eq("mismatch_after_bad", int'(a_mis), 1);
          end else begin
            send_a(8'(w + p));
          end
        end
      end
    end
  endtask

  task automatic wait_got_a(input string tag, input int n);
    int t;
    t = 0;
    while (a_got.size() < n && t < 3000) begin
      t++;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq(tag, a_got.size(), n);
  endtask

  task automatic check_ramp_out(input string tag, input int frames);
    for (int i = 0; i < 66 * frames; i++) begin
      if (i < a_got.size()) check_eq(tag, int'(a_got[i]), i % 66);
    end
  endtask

  initial begin
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_clr = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(a_out_valid), 0);
    check_eq("rst_mismatch", int'(a_mis), 0);
    check_eq("rst_frame_done", int'(a_fd), 0);
    check_eq("rst_in_ready", int'(a_in_ready), 0);
    check_eq("rst_b_out_valid", int'(b_out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain ramp, sink always ready
    a_got.delete();
    a_fd_cnt = 0;
    ramp_frame_a(-1, 192);
    check_eq("fd_on_last_beat", int'(a_fd), 1);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("fd_one_cycle", int'(a_fd), 0);
    wait_got_a("ramp_count", 66);
    check_ramp_out("ramp_data", 1);
    check_eq("ramp_fd_cnt", a_fd_cnt, 1);
    check_eq("ramp_mismatch", int'(a_mis), 0);

    // Corrupt window 5 pos 0 (beat 15)
    a_got.delete();
    ramp_frame_a(15, 192);
    a_in_valid = 1'b0;
    wait_got_a("corrupt_count", 66);
    check_ramp_out("corrupt_data", 1);
    check_eq("mismatch_sticky", int'(a_mis), 1);
    a_clr = 1'b1;
    @(posedge clk);
    #1;
    a_clr = 1'b0;
    check_eq("mismatch_cleared", int'(a_mis), 0);

    // Random backpressure
    a_got.delete();
    a_old_stall = 0;
    bp_en = 1'b1;
    ramp_frame_a(-1, 192);
    a_in_valid = 1'b0;
    bp_en = 1'b0;
    #3;
    a_out_ready = 1'b1;
    wait_got_a("bp_count", 66);
    check_ramp_out("bp_data", 1);
    check_eq("bp_old_during_stall", int'(a_old_stall > 0), 1);
    check_eq("bp_mismatch", int'(a_mis), 0);

    // S==K register-slice mode
    for (int i = 0; i < 12; i++) send_b(8'(i));
    b_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("sk_count", b_got.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < b_got.size()) begin
        check_eq("sk_data", int'(b_got[i]), i);
        check_eq("sk_latency", b_out_cyc[i] - b_in_cyc[i], 1);
      end
    end
    if (b_in_cyc.size() == 12) check_eq("sk_full_rate", b_in_cyc[11] - b_in_cyc[0], 11);
    check_eq("sk_fd_cnt", b_fd_cnt, 1);
    check_eq("sk_mismatch", int'(b_mis), 0);

    // Reset in the middle of a frame
    ramp_frame_a(-1, 50);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_in_ready", int'(a_in_ready), 0);
    check_eq("midrst_out_valid", int'(a_out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_got.delete();
    a_fd_cnt = 0;
    ramp_frame_a(-1, 192);
    a_in_valid = 1'b0;
    wait_got_a("midrst_count", 66);
    check_ramp_out("midrst_data", 1);
    check_eq("midrst_mismatch", int'(a_mis), 0);
    check_eq("midrst_fd_cnt", a_fd_cnt, 1);

    // Two frames back to back
    a_got.delete();
    a_fd_cnt = 0;
    ramp_frame_a(-1, 192);
    ramp_frame_a(-1, 192);
    a_in_valid = 1'b0;
    wait_got_a("b2b_count", 132);
    check_ramp_out("b2b_data", 2);
    check_eq("b2b_fd_cnt", a_fd_cnt, 2);
    check_eq("b2b_mismatch", int'(a_mis), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
